// File: rtl/data_mem_responder.sv
// Single-outstanding word-addressed memory responder with a fixed
// request-to-response latency, byte-lane writes and error reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [2:0]  CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic        w_accept;
    logic        w_enter_resp;

    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;

    logic        w_we;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [AW-1:0] w_idx;
    logic        w_err;

    logic [31:0] r_mem [DEPTH_WORDS];

    // State and latency counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: accept in IDLE, count down in WAIT, hold RESP until taken
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_accept = 1'b1;
                    if (LATENCY <= 1) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        w_enter_resp = (w_state_nxt == RESP) && (r_state != RESP);
    end

    // With LATENCY=1 the array is accessed on the accept edge, so use live inputs in IDLE
    always_comb begin
        if (r_state == IDLE) begin
            w_we    = req_we;
            w_addr  = req_addr;
            w_wdata = req_wdata;
            w_wstrb = req_wstrb;
        end else begin
            w_we    = r_we;
            w_addr  = r_addr;
            w_wdata = r_wdata;
            w_wstrb = r_wstrb;
        end
        w_idx = w_addr[AW+1:2];
        w_err = (w_addr[1:0] != 2'b00) || (w_addr[31:AW+2] != '0);
    end

    // Request capture; later input changes are ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_wstrb <= 4'd0;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    // Registered handshake and response outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= (w_state_nxt == RESP);
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_err || w_we) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Storage array; not reset, written only on a valid access entering RESP
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY 2, 1 and 7.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    logic [2:0]  rdy;
    logic [2:0]  vld;
    logic [2:0]  err;
    logic [31:0] rdata0, rdata1, rdata2;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc      [3];
    int prev_acc [3];
    logic [2:0] pv = 3'b000;

    logic [32:0] q0 [$];
    logic [32:0] q1 [$];
    logic [32:0] q2 [$];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(vld[0]), .resp_ready(resp_ready), .resp_rdata(rdata0), .resp_err(err[0]));

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(vld[1]), .resp_ready(resp_ready), .resp_rdata(rdata1), .resp_err(err[1]));

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(7)) u_l7 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(rdy[2]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(vld[2]), .resp_ready(resp_ready), .resp_rdata(rdata2), .resp_err(err[2]));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 7;
    endfunction

    function automatic logic [31:0] rd(input int d);
        return (d == 0) ? rdata0 : (d == 1) ? rdata1 : rdata2;
    endfunction

    function automatic void push(input int d, input logic [32:0] v);
        case (d)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    endfunction

    function automatic logic [32:0] pop(input int d);
        case (d)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Drive one request on DUT d; when track is set, update the model and queue the expected response
    task automatic send(input int d, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] st, input bit track);
        int n;
        logic e;
        int key;
        logic [31:0] expd;
        logic [31:0] w;
        n = 0;
        @(negedge clk);
        while (!rdy[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) chk("req_ready_timeout", 32'd0, 32'd1);
        req_we       = we;
        req_addr     = a;
        req_wdata    = wd;
        req_wstrb    = st;
        req_valid[d] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_wstrb    = 4'($urandom);
        prev_acc[d]  = acc[d];
        acc[d]       = cyc;
        if (track) begin
            e    = (a[1:0] != 2'b00) || (a[31:2] >= 30'd1024);
            key  = d * 4096 + int'(a[11:2]);
            expd = 32'd0;
            if (!e && we) begin
                w = mdl.exists(key) ? mdl[key] : 32'd0;
                for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = wd[8*i +: 8];
                mdl[key] = w;
            end else if (!e) begin
                expd = mdl.exists(key) ? mdl[key] : 32'd0;
            end
            push(d, {e, expd});
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qsize(0) + qsize(1) + qsize(2)) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if ((qsize(0) + qsize(1) + qsize(2)) != 0)
            chk("drain_timeout", 32'(qsize(0) + qsize(1) + qsize(2)), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Response monitor: latency on rising resp_valid, scoreboard compare on handshake
    always @(negedge clk) begin
        logic [32:0] ex;
        for (int d = 0; d < 3; d++) begin
            if (vld[d] && !pv[d]) chk("latency", 32'(cyc - acc[d] + 1), 32'(lat(d)));
            if (vld[d] && resp_ready) begin
                if (qsize(d) == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    ex = pop(d);
                    chk("resp_rdata", rd(d), ex[31:0]);
                    chk("resp_err", 32'(err[d]), 32'(ex[32]));
                end
            end
            pv[d] <= vld[d];
        end
    end

    initial begin
        int n;
        reset      = 1'b0;
        req_valid  = 3'b000;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_wstrb  = 4'd0;
        resp_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            acc[d]      = 0;
            prev_acc[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_req_ready", 32'(rdy[d]), 32'd0);
            chk("rst_resp_valid", 32'(vld[d]), 32'd0);
            chk("rst_rdata", rd(d), 32'd0);
            chk("rst_err", 32'(err[d]), 32'd0);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(rdy[0]), 32'd1);

        // Basic write/read, strobes, errors on LATENCY=2
        send(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(0, 1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b1);
        send(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        send(0, 1'b1, 32'h10, 32'h12345678, 4'h0, 1'b1);
        send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        send(0, 1'b0, 32'h13, 32'h0, 4'h0, 1'b1);
        send(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 1'b1);
        send(0, 1'b1, 32'h1000, 32'h55555555, 4'hF, 1'b1);
        send(0, 1'b1, 32'h2, 32'h66666666, 4'hF, 1'b1);
        send(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
        send(0, 1'b1, 32'hFFC, 32'hA5A5C3C3, 4'hF, 1'b1);
        send(0, 1'b0, 32'hFFC, 32'h0, 4'h0, 1'b1);
        send(0, 1'b0, 32'h1000, 32'h0, 4'h0, 1'b1);
        drain();

        // Back-pressure: response must hold while resp_ready is low
        resp_ready = 1'b0;
        send(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        n = 0;
        while (!vld[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 32'(vld[0]), 32'd1);
            chk("hold_rdata", rdata0, 32'hDEADBEAA);
            chk("hold_req_ready", 32'(rdy[0]), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("ready_in_complete_cycle", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        chk("ready_after_complete", 32'(rdy[0]), 32'd1);
        chk("valid_after_complete", 32'(vld[0]), 32'd0);

        // Reset during WAIT of a write abandons it
        send(0, 1'b1, 32'h20, 32'h11111111, 4'hF, 1'b1);
        drain();
        send(0, 1'b1, 32'h20, 32'h22222222, 4'hF, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(vld[0]), 32'd0);
        chk("midrst_req_ready", 32'(rdy[0]), 32'd0);
        chk("midrst_rdata", rdata0, 32'd0);
        chk("midrst_err", 32'(err[0]), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(vld[0]), 32'd0);
        end
        reset = 1'b1;
        send(0, 1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        drain();

        // Back-to-back throughput on LATENCY=1 and LATENCY=7
        for (int d = 1; d < 3; d++) begin
            for (int i = 0; i < 4; i++) send(d, 1'b1, 32'h40 + 32'(4 * i), $urandom, 4'hF, 1'b1);
            send(d, 1'b1, 32'h44, 32'h0000BB00, 4'h2, 1'b1);
            send(d, 1'b0, 32'h41, 32'h0, 4'h0, 1'b1);
            send(d, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 1'b1);
            for (int i = 0; i < 8; i++) begin
                send(d, 1'b0, 32'h40 + 32'(4 * (i % 4)), 32'h0, 4'h0, 1'b1);
                chk("period", 32'(acc[d] - prev_acc[d]), 32'(lat(d) + 1));
            end
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
